// File: rtl/pci_rx_buffer.sv
// PCI target receive FIFO: byte-masked write capture, burst tracking, TRDY# throttle, FWFT read port.
// Optional parity storage/check enabled by defining PCI_RX_BUFFER_PARITY_EN.
module pci_rx_buffer #(
    parameter int DEPTH    = 8,
    parameter int AW       = 3,
    parameter int HEADROOM = 1
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          Wr_Valid,
    input  logic [31:0]   Wr_Data,
    input  logic [3:0]    Wr_BE,
    input  logic          Wr_Last,
`ifdef PCI_RX_BUFFER_PARITY_EN
    input  logic          Wr_Par,
    output logic          Rd_Par,
    output logic          Par_Err,
`endif
    output logic          Stop,
    input  logic          Rd_En,
    output logic [31:0]   Rd_Data,
    output logic [3:0]    Rd_BE,
    output logic          Rd_Last,
    output logic          Empty,
    output logic          Full,
    output logic [AW:0]   Count,
    output logic [AW:0]   Bursts,
    output logic          Ovf,
    input  logic          Clr_Ovf
);

`ifdef PCI_RX_BUFFER_PARITY_EN
    localparam int EW = 38;
`else
    localparam int EW = 37;
`endif
    localparam logic [AW:0] DEPTH_W    = (AW+1)'(DEPTH);
    localparam logic [AW:0] HEADROOM_W = (AW+1)'(HEADROOM);

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count_q, bursts_q;
    logic          ovf_q;
    state_t        state_q, state_d;
    logic [31:0]   masked_data;
    logic [EW-1:0] wr_entry, head;
    logic          push, pop, burst_inc, burst_dec;

    always_comb begin
        masked_data = '0;
        for (int i = 0; i < 4; i++)
            masked_data[8*i +: 8] = Wr_BE[i] ? 8'h00 : Wr_Data[8*i +: 8];
    end

`ifdef PCI_RX_BUFFER_PARITY_EN
    assign wr_entry = {Wr_Par, Wr_Last, Wr_BE, masked_data};
`else
    assign wr_entry = {Wr_Last, Wr_BE, masked_data};
`endif

    assign head      = mem[rd_ptr];
    assign Empty     = (count_q == '0);
    assign Full      = (count_q == DEPTH_W);
    // Full is sampled before any same-cycle pop, so a write at Count=DEPTH is dropped.
    assign push      = Wr_Valid & ~Full;
    assign pop       = Rd_En & ~Empty;
    assign burst_inc = push & Wr_Last;
    assign burst_dec = pop & head[36];

    always_ff @(posedge Clk) begin
        if (push)
            mem[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            bursts_q <= '0;
            ovf_q    <= 1'b0;
            state_q  <= IDLE;
        end else begin
            state_q <= state_d;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count_q <= count_q + 1'b1;
            else if (pop && !push)
                count_q <= count_q - 1'b1;
            if (burst_inc && !burst_dec)
                bursts_q <= bursts_q + 1'b1;
            else if (burst_dec && !burst_inc)
                bursts_q <= bursts_q - 1'b1;
            if (Wr_Valid && Full)
                ovf_q <= 1'b1;
            else if (Clr_Ovf)
                ovf_q <= 1'b0;
        end
    end

    // Burst tracking follows every completed phase, dropped or not.
    always_comb begin
        state_d = state_q;
        Stop    = ((DEPTH_W - count_q) <= HEADROOM_W);
        case (state_q)
            IDLE:   if (Wr_Valid && !Wr_Last) state_d = ACTIVE;
            ACTIVE: begin
                if (ovf_q)
                    Stop = 1'b1;
                if (Wr_Valid && Wr_Last)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign Count   = count_q;
    assign Bursts  = bursts_q;
    assign Ovf     = ovf_q;
    assign Rd_Data = Empty ? 32'h0 : head[31:0];
    assign Rd_BE   = Empty ? 4'hF  : head[35:32];
    assign Rd_Last = Empty ? 1'b0  : head[36];

`ifdef PCI_RX_BUFFER_PARITY_EN
    logic par_err_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            par_err_q <= 1'b0;
        else if (push && (^{Wr_Data, Wr_BE, Wr_Par}))
            par_err_q <= 1'b1;
        else if (Clr_Ovf)
            par_err_q <= 1'b0;
    end

    assign Par_Err = par_err_q;
    assign Rd_Par  = Empty ? 1'b0 : head[37];
`endif

endmodule
